// File: rtl/jpeg_ff_stuffer.sv
// JPEG output byte stuffer: serialises 32-bit FIFO words MSB first,
// inserts 0x00 after each 0xFF data byte and appends the EOI marker.
module jpeg_ff_stuffer #(
  parameter logic [7:0]  STUFF_BYTE = 8'h00,
  parameter logic [15:0] EOI_MARKER = 16'hFFD9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_read_data,
  input  logic        fifo_rdata_valid,
  output logic        fifo_read_req,
  input  logic        eoi_req,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        eoi_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    EMIT,
    STUFF,
    EOI_FF,
    EOI_D9
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic [31:0] word, word_nx;
  logic        eoi_pending, pend_nx;
  logic [7:0]  cur_byte;
  logic [7:0]  byte_nx;
  logic        load;
  logic        done_nx;
  logic        slot_free;

  assign slot_free = !out_valid || out_ready;

  assign fifo_read_req = (state == IDLE) && !fifo_empty && !rst;

  assign busy = (state != IDLE) || out_valid || eoi_pending;

  // select the byte of the held word addressed by idx, MSB first
  always_comb begin
    cur_byte = word[31:24];
    unique case (idx)
      2'd0: cur_byte = word[31:24];
      2'd1: cur_byte = word[23:16];
      2'd2: cur_byte = word[15:8];
      2'd3: cur_byte = word[7:0];
      default: cur_byte = word[31:24];
    endcase
  end

  // next state, byte selection and output-slot loading
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    word_nx  = word;
    load     = 1'b0;
    byte_nx  = out_byte;
    done_nx  = 1'b0;
    pend_nx  = eoi_pending || eoi_req;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nx = WAIT;
        end else if (eoi_pending) begin
          state_nx = EOI_FF;
        end
      end
      WAIT: begin
        if (fifo_rdata_valid) begin
          word_nx  = fifo_read_data;
          idx_nx   = 2'd0;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (slot_free) begin
          load    = 1'b1;
          byte_nx = cur_byte;
          if (cur_byte == 8'hFF) begin
            state_nx = STUFF;
          end else if (idx == 2'd3) begin
            state_nx = IDLE;
          end else begin
            idx_nx = idx + 2'd1;
          end
        end
      end
      STUFF: begin
        if (slot_free) begin
          load    = 1'b1;
          byte_nx = STUFF_BYTE;
          if (idx == 2'd3) begin
            state_nx = IDLE;
          end else begin
            idx_nx   = idx + 2'd1;
            state_nx = EMIT;
          end
        end
      end
      EOI_FF: begin
        if (slot_free) begin
          load     = 1'b1;
          byte_nx  = EOI_MARKER[15:8];
          state_nx = EOI_D9;
        end
      end
      EOI_D9: begin
        if (slot_free) begin
          load     = 1'b1;
          byte_nx  = EOI_MARKER[7:0];
          done_nx  = 1'b1;
          pend_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, word and output register; a held byte stays put while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      word        <= 32'h0;
      eoi_pending <= 1'b0;
      out_byte    <= 8'h00;
      out_valid   <= 1'b0;
      eoi_done    <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      word        <= word_nx;
      eoi_pending <= pend_nx;
      eoi_done    <= done_nx;
      if (load) begin
        out_byte  <= byte_nx;
        out_valid <= 1'b1;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Bench for jpeg_ff_stuffer: FIFO model, stuffed-stream scoreboard,
// directed scenarios and randomized traffic with random back-pressure.
module tb_jpeg_ff_stuffer;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [31:0] fifo_read_data;
  logic        fifo_rdata_valid;
  logic        fifo_read_req;
  logic        eoi_req;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        eoi_done;
  logic        busy;

  jpeg_ff_stuffer dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .fifo_rdata_valid (fifo_rdata_valid),
    .fifo_read_req    (fifo_read_req),
    .eoi_req          (eoi_req),
    .out_byte         (out_byte),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .eoi_done         (eoi_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_reads = 0;
  int n_pushed = 0;
  int n_eoi_done = 0;
  int n_eoi_exp = 0;
  int cyc = 0;
  int tg = 0;
  int rdy_mode = 0;
  bit spur_en = 0;
  logic eoi_next = 1'b0;
  logic rst_next = 1'b1;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  int          cap_t[$];

  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [7:0] p_byte = 8'h00;
  logic       p_rst = 1'b0;

  function automatic void chk(input bit ok, input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  // the model: a word becomes its four bytes, each 0xFF followed by 0x00
  function automatic void push_word(input logic [31:0] w);
    logic [7:0] b;
    fifo_q.push_back(w);
    n_pushed++;
    for (int i = 3; i >= 0; i--) begin
      b = w[8*i +: 8];
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void push_eoi();
    eoi_next = 1'b1;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    n_eoi_exp++;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) == 0) w[8*i +: 8] = 8'hFF;
      else w[8*i +: 8] = 8'($urandom);
    end
    return w;
  endfunction

  // one clock: sample the read request mid-cycle, answer after the edge
  task automatic step();
    logic req;
    @(negedge clk);
    req = fifo_read_req;
    @(posedge clk);
    #1;
    eoi_req  = eoi_next;
    eoi_next = 1'b0;
    rst      = rst_next;
    if (req) begin
      chk(fifo_q.size() != 0, "read_when_empty", 0, 1);
      if (fifo_q.size() != 0) begin
        fifo_read_data   = fifo_q.pop_front();
        fifo_rdata_valid = 1'b1;
        n_reads++;
      end
    end else begin
      fifo_read_data   = $urandom;
      fifo_rdata_valid = spur_en && ($urandom_range(0, 7) == 0);
    end
    fifo_empty = (fifo_q.size() == 0);
    tg++;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 2) != 0);
      2:       out_ready = (tg % 3 == 0);
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (k < 400 && (exp_q.size() != 0 || fifo_q.size() != 0 ||
                       busy || out_valid)) begin
      step();
      k++;
    end
    chk(k < 400, {nm, "_drain_timeout"}, k, 400);
    chk(n_reads == n_pushed, {nm, "_read_count"}, n_reads, n_pushed);
  endtask

  task automatic check_cap(input string nm, input bq_t e);
    bit ok;
    logic [31:0] a, x;
    ok = (cap_q.size() == e.size());
    a  = cap_q.size();
    x  = e.size();
    if (ok) begin
      foreach (e[i]) begin
        if (ok && cap_q[i] != e[i]) begin
          ok = 0;
          a  = {24'h0, cap_q[i]};
          x  = {24'h0, e[i]};
        end
      end
    end
    chk(ok, nm, a, x);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle compare against the scoreboard and the handshake rules
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) chk(!fifo_read_req, "req_in_rst", 32'(fifo_read_req), 0);
    if (p_rst) begin
      chk(!out_valid && !eoi_done, "rst_clear",
          32'({out_valid, eoi_done}), 0);
    end else if (p_valid && !p_ready) begin
      chk(out_valid && out_byte == p_byte, "stall_hold",
          32'({out_valid, out_byte}), 32'({1'b1, p_byte}));
    end
    if (eoi_done) begin
      n_eoi_done++;
      chk(out_valid && out_byte == 8'hD9, "eoi_done_d9",
          32'({out_valid, out_byte}), 32'h1D9);
    end
    if (out_valid && out_ready) begin
      cap_q.push_back(out_byte);
      cap_t.push_back(cyc);
      chk(exp_q.size() != 0, "extra_byte", 32'(out_byte), 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(out_byte == e, "byte", 32'(out_byte), 32'(e));
      end
    end
    p_valid = out_valid;
    p_ready = out_ready;
    p_byte  = out_byte;
    p_rst   = rst;
  end

  initial begin
    bq_t e;
    int  r0, d0, nw;
    bit  found;
    rst              = 1'b1;
    fifo_empty       = 1'b1;
    fifo_read_data   = 32'h0;
    fifo_rdata_valid = 1'b0;
    eoi_req          = 1'b0;
    out_ready        = 1'b0;

    repeat (3) step();
    chk(!out_valid, "rst_out_valid", 32'(out_valid), 0);
    chk(out_byte == 8'h00, "rst_out_byte", 32'(out_byte), 0);
    chk(!eoi_done, "rst_eoi_done", 32'(eoi_done), 0);
    chk(!busy, "rst_busy", 32'(busy), 0);
    rst_next = 1'b0;
    step();

    // plain word
    cap_q.delete();
    r0 = n_reads;
    push_word(32'h12345678);
    drain("w1");
    e = {8'h12, 8'h34, 8'h56, 8'h78};
    check_cap("w1_seq", e);
    chk(n_reads - r0 == 1, "w1_reads", n_reads - r0, 1);

    // all 0xFF, including the last byte
    cap_q.delete();
    r0 = n_reads;
    push_word(32'hFFFFFFFF);
    drain("ff");
    e = {8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    check_cap("ff_seq", e);
    chk(n_reads - r0 == 1, "ff_reads", n_reads - r0, 1);

    // back-pressure pattern 1,0,0
    cap_q.delete();
    rdy_mode = 2;
    tg = 0;
    push_word(32'h00FF00FF);
    drain("stall");
    e = {8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    check_cap("stall_seq", e);
    rdy_mode = 0;

    // EOI requested mid-word, second word still queued
    cap_q.delete();
    d0 = n_eoi_done;
    push_word(32'hABCDEF01);
    push_word(32'h11223344);
    for (int i = 0; i < 20 && cap_q.size() == 0; i++) step();
    push_eoi();
    drain("eoi_mid");
    e = {8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
         8'hFF, 8'hD9};
    check_cap("eoi_mid_seq", e);
    chk(n_eoi_done - d0 == 1, "eoi_mid_done", n_eoi_done - d0, 1);

    // reset right after a 0xFF is loaded: its stuff byte is lost
    cap_q.delete();
    fifo_q.push_back(32'hFF000000);
    n_pushed++;
    exp_q.push_back(8'hFF);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = out_valid && out_byte == 8'hFF;
    end
    chk(found, "rst_ff_seen", 32'(found), 1);
    rst = 1'b1;
    rst_next = 1'b1;
    step();
    push_word(32'h12345678);
    step();
    step();
    rst_next = 1'b0;
    drain("rst_mid");
    e = {8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};
    check_cap("rst_mid_seq", e);

    // idle EOI; a repeat request while pending is ignored
    cap_q.delete();
    cap_t.delete();
    d0 = n_eoi_done;
    push_eoi();
    step();
    step();
    eoi_next = 1'b1;
    drain("eoi_idle");
    e = {8'hFF, 8'hD9};
    check_cap("eoi_idle_seq", e);
    if (cap_t.size() == 2)
      chk(cap_t[1] - cap_t[0] == 1, "eoi_back_to_back",
          cap_t[1] - cap_t[0], 1);
    chk(n_eoi_done - d0 == 1, "eoi_idle_done", n_eoi_done - d0, 1);

    // randomized traffic
    rdy_mode = 1;
    spur_en = 1;
    for (int b = 0; b < 40; b++) begin
      nw = $urandom_range(1, 4);
      for (int j = 0; j < nw; j++) begin
        push_word(rand_word());
        repeat ($urandom_range(0, 6)) step();
      end
      if ($urandom_range(0, 1) == 1) push_eoi();
      drain("rand");
    end
    chk(n_eoi_done == n_eoi_exp, "eoi_total", n_eoi_done, n_eoi_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
